// File: rtl/reduce_rr_sched.sv
// Round-robin front end that shares one variable-latency modular-reduction core
// between NUM_REQ requesters, with a watchdog that retires a hung core transaction.
module reduce_rr_sched #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_LENGTH    = 32,
  parameter int MODULUS        = 3329,
  parameter int MODULUS_LENGTH = 12,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NUM_REQ-1:0]             req_i,
  input  logic [NUM_REQ*DATA_LENGTH-1:0] x_i,
  output logic [NUM_REQ-1:0]             gnt_o,
  output logic [NUM_REQ-1:0]             rsp_valid_o,
  output logic [DATA_LENGTH-1:0]         rsp_data_o,
  output logic                           rsp_err_o,
  output logic                           busy_o,
  output logic                           core_start_o,
  output logic [DATA_LENGTH-1:0]         core_x_o,
  output logic [DATA_LENGTH-1:0]         core_m_o,
  output logic [DATA_LENGTH-1:0]         core_m_bl_o,
  input  logic [DATA_LENGTH-1:0]         core_result_i,
  input  logic                           core_valid_i
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                 state_q, state_d;
  logic [IW-1:0]          last_q, last_d, sel_q, sel_d, pick;
  logic [WW-1:0]          wd_q, wd_d;
  logic [DATA_LENGTH-1:0] res_q, res_d, rsp_data_q, rsp_data_d, x_q, x_d;
  logic                   err_q, err_d, rsp_err_q, rsp_err_d;
  logic                   busy_q, busy_d, start_q, start_d, found;
  logic [NUM_REQ-1:0]     gnt_q, gnt_d, rsp_valid_q, rsp_valid_d;
  logic [DATA_LENGTH-1:0] x_arr [NUM_REQ];
  int                     idx;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign x_arr[g] = x_i[g*DATA_LENGTH +: DATA_LENGTH];
  end

  // Scan starts just after the last served requester, so it becomes lowest priority.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = int'(last_q) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req_i[IW'(idx)]) begin
        found = 1'b1;
        pick  = IW'(idx);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    sel_d       = sel_q;
    wd_d        = wd_q;
    res_d       = res_q;
    err_d       = err_q;
    x_d         = x_q;
    gnt_d       = '0;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    start_d     = 1'b0;
    case (state_q)
      IDLE: if (found) begin
        x_d        = x_arr[pick];
        gnt_d[pick] = 1'b1;
        sel_d      = pick;
        state_d    = ISSUE;
      end
      ISSUE: begin
        start_d = 1'b1;
        wd_d    = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // A valid pulse on the expiry cycle still counts as a good result.
        if (core_valid_i) begin
          res_d   = core_result_i;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (wd_q == WW'(TIMEOUT_CYCLES-2)) begin
          res_d   = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      RESP: begin
        rsp_valid_d[sel_q] = 1'b1;
        rsp_data_d         = res_q;
        rsp_err_d          = err_q;
        last_d             = sel_q;
        state_d            = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      last_q      <= IW'(NUM_REQ-1);
      sel_q       <= '0;
      wd_q        <= '0;
      res_q       <= '0;
      err_q       <= 1'b0;
      x_q         <= '0;
      gnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      start_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      sel_q       <= sel_d;
      wd_q        <= wd_d;
      res_q       <= res_d;
      err_q       <= err_d;
      x_q         <= x_d;
      gnt_q       <= gnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      busy_q      <= busy_d;
      start_q     <= start_d;
    end
  end

  assign gnt_o        = gnt_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_data_o   = rsp_data_q;
  assign rsp_err_o    = rsp_err_q;
  assign busy_o       = busy_q;
  assign core_start_o = start_q;
  assign core_x_o     = x_q;
  assign core_m_o     = DATA_LENGTH'(MODULUS);
  assign core_m_bl_o  = DATA_LENGTH'(MODULUS_LENGTH);
endmodule

// File: tb/tb_reduce_rr_sched.sv
// Bench for reduce_rr_sched: behavioural core model, round-robin reference and a
// grant-to-response scoreboard checked by an independent monitor.
module tb_reduce_rr_sched;
  localparam int NR = 4, DW = 32, MODV = 3329, TO = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_i;
  logic [NR-1:0]      req_i;
  logic [NR*DW-1:0]   x_i;
  logic [NR-1:0]      gnt_o, rsp_valid_o;
  logic [DW-1:0]      rsp_data_o, core_x_o, core_m_o, core_m_bl_o;
  logic               rsp_err_o, busy_o, core_start_o;
  logic [DW-1:0]      core_result_i = '0;
  logic               core_valid_i = 1'b0;

  logic [DW-1:0] xv [NR];
  int checks = 0, errors = 0, cyc = 0, core_lat = 5;

  reduce_rr_sched #(.NUM_REQ(NR), .DATA_LENGTH(DW), .MODULUS(MODV),
                    .MODULUS_LENGTH(12), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .x_i(x_i),
    .gnt_o(gnt_o), .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o),
    .rsp_err_o(rsp_err_o), .busy_o(busy_o), .core_start_o(core_start_o),
    .core_x_o(core_x_o), .core_m_o(core_m_o), .core_m_bl_o(core_m_bl_o),
    .core_result_i(core_result_i), .core_valid_i(core_valid_i));

  always_comb begin
    x_i = '0;
    for (int k = 0; k < NR; k++) x_i[k*DW +: DW] = xv[k];
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int rr_pick(input logic [NR-1:0] r, input int last);
    for (int i = 1; i <= NR; i++)
      if (r[(last+i)%NR]) return (last+i)%NR;
    return -1;
  endfunction

  // Core model: answers x mod MODV core_lat cycles after start; core_lat==0 never answers.
  int cnt = 0;
  logic [DW-1:0] pend = '0;
  always @(negedge clk) begin
    core_valid_i  = 1'b0;
    core_result_i = DW'($urandom());
    if (cnt > 0) begin
      cnt--;
      if (cnt == 0) begin
        core_valid_i  = 1'b1;
        core_result_i = DW'(pend % MODV);
      end
    end
    if (core_start_o && !rst_i) begin
      cnt  = core_lat;
      pend = core_x_o;
    end
  end

  // Scoreboard and monitor.
  typedef struct { int k; logic [DW-1:0] x; int lat; } tx_t;
  tx_t q[$];
  tx_t t;
  int gnt_log[$];
  int start_due = -1, start_cyc = 0, last_m = NR-1, ek, dt;
  logic [NR-1:0] prev_req = '0;
  logic [DW-1:0] prev_xv [NR];
  logic [DW-1:0] exp_d;
  logic exp_e;

  always @(negedge clk) begin
    cyc++;
    if (rst_i) begin
      q.delete();
      start_due = -1;
      last_m    = NR-1;
    end else begin
      if (gnt_o != '0) begin
        ek = rr_pick(prev_req, last_m);
        chk("gnt_onehot", 64'($onehot(gnt_o)), 64'd1);
        chk("gnt_rr", 64'(gnt_o), (ek < 0) ? 64'd0 : (64'd1 << ek));
        for (int k = 0; k < NR; k++)
          if (gnt_o[k]) begin
            q.push_back('{k: k, x: prev_xv[k], lat: core_lat});
            gnt_log.push_back(k);
            last_m = k;
          end
        start_due = cyc + 1;
      end
      if (core_start_o || start_due == cyc) begin
        chk("start_timing", 64'(core_start_o), 64'(start_due == cyc));
        if (core_start_o && q.size() > 0) chk("core_x", 64'(core_x_o), 64'(q[0].x));
        start_cyc = cyc;
      end
      if (rsp_valid_o != '0) begin
        if (q.size() == 0) chk("rsp_unexpected", 64'(rsp_valid_o), 64'd0);
        else begin
          t = q.pop_front();
          if (t.lat >= 1 && t.lat <= TO-2) begin
            exp_d = DW'(t.x % MODV); exp_e = 1'b0; dt = t.lat + 2;
          end else begin
            exp_d = '0; exp_e = 1'b1; dt = TO;
          end
          chk("rsp_valid", 64'(rsp_valid_o), 64'd1 << t.k);
          chk("rsp_data", 64'(rsp_data_o), 64'(exp_d));
          chk("rsp_err", 64'(rsp_err_o), 64'(exp_e));
          chk("rsp_latency", 64'(cyc - start_cyc), 64'(dt));
        end
      end
    end
    prev_req = req_i;
    for (int k = 0; k < NR; k++) prev_xv[k] = xv[k];
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_gnt"}, 64'(gnt_o), 64'd0);
    chk({tag, "_rsp_valid"}, 64'(rsp_valid_o), 64'd0);
    chk({tag, "_rsp_data"}, 64'(rsp_data_o), 64'd0);
    chk({tag, "_rsp_err"}, 64'(rsp_err_o), 64'd0);
    chk({tag, "_busy"}, 64'(busy_o), 64'd0);
    chk({tag, "_start"}, 64'(core_start_o), 64'd0);
    chk({tag, "_core_x"}, 64'(core_x_o), 64'd0);
  endtask

  task automatic do_reset();
    req_i = '0; rst_i = 1'b1;
    tick(); tick();
    rst_i = 1'b0;
    tick();
  endtask

  // Hold each masked request until its own grant, then drop it.
  task automatic serve(input logic [NR-1:0] mask);
    int n = 0;
    req_i = req_i | mask;
    while ((req_i & mask) != '0 && n < 500) begin
      tick(); n++;
      req_i = req_i & ~gnt_o;
    end
    chk("serve_granted", 64'(req_i & mask), 64'd0);
    req_i = req_i & ~mask;
  endtask

  task automatic wait_grants(input int n);
    int c = 0;
    while (gnt_log.size() < n && c < 2000) begin tick(); c++; end
    chk("wait_grants", 64'(gnt_log.size()), 64'(n));
  endtask

  task automatic drain();
    int c = 0;
    req_i = '0;
    while ((busy_o || q.size() != 0) && c < 300) begin tick(); c++; end
    chk("drain_idle", 64'(!busy_o && q.size() == 0), 64'd1);
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not reach the end");
    $fatal(1);
  end

  initial begin
    int c;
    int exp4[6] = '{0, 2, 0, 1, 2, 0};
    rst_i = 1'b1; req_i = '0;
    for (int k = 0; k < NR; k++) xv[k] = '0;
    repeat (3) tick();
    chk_reset("por");
    chk("core_m", 64'(core_m_o), 64'(MODV));
    chk("core_m_bl", 64'(core_m_bl_o), 64'd12);
    rst_i = 1'b0;
    tick();

    // Single request, latency 5.
    gnt_log.delete();
    core_lat = 5; xv[0] = 32'h1A2B;
    serve(4'b0001);
    drain();
    chk("single_data", 64'(rsp_data_o), 64'h29);
    chk("single_err", 64'(rsp_err_o), 64'd0);
    chk("single_gnt", 64'(gnt_log[0]), 64'd0);

    // All four held: strict rotation starting from 0.
    do_reset(); gnt_log.delete();
    for (int k = 0; k < NR; k++) xv[k] = DW'(MODV + k);
    core_lat = 3; req_i = '1;
    wait_grants(8);
    drain();
    for (int i = 0; i < 8; i++) chk("rr_order", 64'(gnt_log[i]), 64'(i % NR));

    // 0 and 2 alternate; late requester 1 is served ahead of 0.
    do_reset(); gnt_log.delete();
    for (int k = 0; k < NR; k++) xv[k] = DW'($urandom());
    core_lat = 2; req_i = 4'b0101;
    wait_grants(3);
    req_i[1] = 1'b1;
    wait_grants(6);
    drain();
    for (int i = 0; i < 6; i++) chk("alt_order", 64'(gnt_log[i]), 64'(exp4[i]));

    // Watchdog: no answer, a late answer, and an answer on the expiry cycle.
    core_lat = 0; xv[1] = 32'd100;
    serve(4'b0010); drain();
    chk("to_data", 64'(rsp_data_o), 64'd0);
    chk("to_err", 64'(rsp_err_o), 64'd1);
    core_lat = TO-1; xv[2] = 32'd5000;
    serve(4'b0100); drain();
    chk("late_err", 64'(rsp_err_o), 64'd1);
    core_lat = TO-2; xv[3] = 32'd7000;
    serve(4'b1000); drain();
    chk("edge_data", 64'(rsp_data_o), 64'd342);
    chk("edge_err", 64'(rsp_err_o), 64'd0);

    // Reset while waiting on the core; the stale pulse lands while idle.
    core_lat = 10; xv[0] = 32'd1234;
    serve(4'b0001);
    c = 0;
    while (!core_start_o && c < 50) begin tick(); c++; end
    chk("start_seen", 64'(core_start_o), 64'd1);
    tick(); tick();
    rst_i = 1'b1;
    tick();
    chk_reset("wait_rst");
    rst_i = 1'b0;
    repeat (12) tick();
    chk("post_rst_idle", 64'(busy_o), 64'd0);
    gnt_log.delete();
    core_lat = 4; xv[1] = 32'd0; xv[2] = 32'd3329;
    serve(4'b0110);
    drain();
    chk("rst_first", 64'(gnt_log[0]), 64'd1);
    chk("rst_second", 64'(gnt_log[1]), 64'd2);
    chk("rst_data", 64'(rsp_data_o), 64'd0);

    // Random traffic with random core latency, including timeouts.
    for (int i = 0; i < 1500; i++) begin
      tick();
      if (gnt_o != '0) core_lat = $urandom_range(1, 17);
      for (int k = 0; k < NR; k++) begin
        if (gnt_o[k]) begin
          if ($urandom_range(0, 1) == 0) req_i[k] = 1'b0;
          xv[k] = DW'($urandom());
        end else if (!req_i[k] && $urandom_range(0, 7) == 0) begin
          req_i[k] = 1'b1;
          xv[k] = DW'($urandom());
        end
      end
    end
    drain();
    chk("sb_empty", 64'(q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
